reset_sequencer: RTL



---
 rtl/reset_sequencer_pkg.sv | 17 +
 rtl/reset_sequencer_sync.sv | 53 +++++
 rtl/reset_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer.
// State encodings, reset cause codes and a sizing helper.
package reset_sequencer_pkg;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset deassertion synchroniser: a chain of async-set flops.
// Ports: clk, clr (async set), sync_rst (synchronised, active high).
module dff_async_set (
  input  logic clk,
  input  logic set,
  input  logic ce,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      q <= 1'b1;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

module reset_sync #(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic clr,
  output logic sync_rst
);

  logic [sync_stages-1:0] q;

  for (genvar i = 0; i < sync_stages; i++) begin : g_chain
    if (i == 0) begin : g_first
      dff_async_set u_ff (
        .clk (clk),
        .set (clr),
        .ce  (1'b1),
        .d   (1'b0),
        .q   (q[0])
      );
    end else begin : g_next
      dff_async_set u_ff (
        .clk (clk),
        .set (clr),
        .ce  (1'b1),
        .d   (q[i-1]),
        .q   (q[i])
      );
    end
  end

  assign sync_rst = q[sync_stages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: async assert, sync staged release.
// Ports: clk, clr, sw_rst_req in; rst_out, ready, sw_rst_ack, rst_cause out.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int sync_stages = 2,
  parameter int hold_cycles = 16,
  parameter int nout        = 3,
  parameter int stage_gap   = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            sw_rst_req,
  output logic [nout-1:0] rst_out,
  output logic            ready,
  output logic            sw_rst_ack,
  output logic [1:0]      rst_cause
);

  localparam int CW = $clog2(max2(hold_cycles, stage_gap)) + 1;
  localparam int IW = $clog2(nout) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(hold_cycles - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(stage_gap - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(nout - 1);

  logic          sync_rst;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  reset_sync #(
    .sync_stages (sync_stages)
  ) u_sync (
    .clk      (clk),
    .clr      (clr),
    .sync_rst (sync_rst)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      rst_out    <= '1;
      ready      <= 1'b0;
      sw_rst_ack <= 1'b0;
      rst_cause  <= CAUSE_EXT;
    end else begin
      sw_rst_ack <= 1'b0;
      unique case (state)
        ST_ASSERT: begin
          if (!sync_rst) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_out[0] <= 1'b0;
            cnt        <= '0;
            idx        <= IW'(1);
            if (nout == 1) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            // mask form avoids an index wider than rst_out
            rst_out <= rst_out & ~(nout'(1) << idx);
            idx     <= idx + IW'(1);
            cnt     <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (sw_rst_req) begin
            rst_out    <= '1;
            ready      <= 1'b0;
            rst_cause  <= CAUSE_SW;
            sw_rst_ack <= 1'b1;
            state      <= ST_HOLD;
            cnt        <= '0;
            idx        <= '0;
          end
        end
        default: begin
          state <= ST_ASSERT;
        end
      endcase
    end
  end

endmodule
